// File: rtl/ycr_mcore_mem_arb.sv
// Round-robin arbiter sharing one ycr memory slave port among NREQ masters.
// Ports: clk/rst, per-master m_* request/response buses, muxed s_* slave bus, gnt_id/busy/tmo_err status.
module ycr_mcore_mem_arb #(
  parameter int NREQ = 4,
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int BW   = 3,
  parameter int TMO  = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            m_req,
  output logic [NREQ-1:0]            m_req_ack,
  input  logic [NREQ-1:0]            m_cmd,
  input  logic [2*NREQ-1:0]          m_width,
  input  logic [AW*NREQ-1:0]         m_addr,
  input  logic [BW*NREQ-1:0]         m_bl,
  input  logic [DW*NREQ-1:0]         m_wdata,
  output logic [DW*NREQ-1:0]         m_rdata,
  output logic [2*NREQ-1:0]          m_resp,
  output logic                       s_req,
  input  logic                       s_req_ack,
  output logic                       s_cmd,
  output logic [1:0]                 s_width,
  output logic [AW-1:0]              s_addr,
  output logic [BW-1:0]              s_bl,
  output logic [DW-1:0]              s_wdata,
  input  logic [DW-1:0]              s_rdata,
  input  logic [1:0]                 s_resp,
  output logic [$clog2(NREQ)-1:0]    gnt_id,
  output logic                       busy,
  output logic                       tmo_err
);

  localparam int GW = $clog2(NREQ);
  localparam int TW = (TMO < 2) ? 1 : $clog2(TMO);

  localparam logic [1:0] RSP_NOTRDY = 2'b00;
  localparam logic [1:0] RSP_ER     = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_gnt;
  logic [GW-1:0] w_gnt_nxt;
  logic [GW-1:0] r_last;
  logic [GW-1:0] w_last_nxt;
  logic [BW-1:0] r_cnt;
  logic [BW-1:0] w_cnt_nxt;
  logic [TW-1:0] r_wd;
  logic [TW-1:0] w_wd_nxt;
  logic          r_tmo;
  logic          w_tmo_set;

  logic [GW-1:0] w_sel;
  logic [GW-1:0] w_idx;
  logic          w_any;

  logic          w_g_req;
  logic          w_g_cmd;
  logic [1:0]    w_g_width;
  logic [AW-1:0] w_g_addr;
  logic [BW-1:0] w_g_bl;
  logic [BW-1:0] w_g_bl_eff;
  logic [DW-1:0] w_g_wdata;
  logic          w_wd_hit;

  // Round-robin scan starting just after the last accepted master.
  always_comb begin
    w_sel = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = GW'((int'(r_last) + i) % NREQ);
      if (!w_any && m_req[w_idx]) begin
        w_sel = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_g_req    = m_req[r_gnt];
  assign w_g_cmd    = m_cmd[r_gnt];
  assign w_g_width  = m_width[int'(r_gnt)*2 +: 2];
  assign w_g_addr   = m_addr[int'(r_gnt)*AW +: AW];
  assign w_g_bl     = m_bl[int'(r_gnt)*BW +: BW];
  assign w_g_wdata  = m_wdata[int'(r_gnt)*DW +: DW];
  assign w_g_bl_eff = (w_g_bl == '0) ? BW'(1) : w_g_bl;
  assign w_wd_hit   = (TMO != 0) && (r_wd == TW'(TMO - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_wd_nxt    = r_wd;
    w_tmo_set   = 1'b0;
    s_req       = 1'b0;
    s_cmd       = 1'b0;
    s_width     = '0;
    s_addr      = '0;
    s_bl        = '0;
    s_wdata     = '0;
    m_req_ack   = '0;
    m_resp      = '0;
    m_rdata     = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_nxt   = w_sel;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        s_req            = w_g_req;
        s_cmd            = w_g_cmd;
        s_width          = w_g_width;
        s_addr           = w_g_addr;
        s_bl             = w_g_bl;
        s_wdata          = w_g_wdata;
        m_req_ack[r_gnt] = s_req_ack;
        if (!w_g_req) begin
          // Master withdrew before acceptance: drop it, keep priority.
          w_state_nxt = ST_IDLE;
        end else if (s_req_ack) begin
          w_last_nxt  = r_gnt;
          w_cnt_nxt   = w_g_cmd ? BW'(1) : w_g_bl_eff;
          w_wd_nxt    = '0;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        m_resp[int'(r_gnt)*2 +: 2]   = s_resp;
        m_rdata[int'(r_gnt)*DW +: DW] = s_rdata;
        if (s_resp != RSP_NOTRDY) begin
          w_cnt_nxt = r_cnt - BW'(1);
          w_wd_nxt  = '0;
          if (r_cnt == BW'(1) || s_resp == RSP_ER) begin
            w_state_nxt = ST_IDLE;
          end
        end else if (TMO != 0) begin
          if (w_wd_hit) begin
            m_resp[int'(r_gnt)*2 +: 2] = RSP_ER;
            w_tmo_set   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_wd_nxt = r_wd + TW'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_last  <= GW'(NREQ - 1);
      r_cnt   <= '0;
      r_wd    <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wd    <= w_wd_nxt;
      r_tmo   <= r_tmo | w_tmo_set;
    end
  end

  assign gnt_id  = r_gnt;
  assign busy    = (r_state != ST_IDLE);
  assign tmo_err = r_tmo;

endmodule

// File: tb/tb_ycr_mcore_mem_arb.sv
// Directed bench for ycr_mcore_mem_arb.
// Covers reset, single/burst read, round robin, error abort, watchdog, async reset.
module tb_ycr_mcore_mem_arb;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = 3;
  localparam int TMO  = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      m_req;
  logic [NREQ-1:0]      m_req_ack;
  logic [NREQ-1:0]      m_cmd;
  logic [2*NREQ-1:0]    m_width;
  logic [AW*NREQ-1:0]   m_addr;
  logic [BW*NREQ-1:0]   m_bl;
  logic [DW*NREQ-1:0]   m_wdata;
  logic [DW*NREQ-1:0]   m_rdata;
  logic [2*NREQ-1:0]    m_resp;
  logic                 s_req;
  logic                 s_req_ack;
  logic                 s_cmd;
  logic [1:0]           s_width;
  logic [AW-1:0]        s_addr;
  logic [BW-1:0]        s_bl;
  logic [DW-1:0]        s_wdata;
  logic [DW-1:0]        s_rdata;
  logic [1:0]           s_resp;
  logic [1:0]           gnt_id;
  logic                 busy;
  logic                 tmo_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ycr_mcore_mem_arb #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .BW(BW), .TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_req_ack(m_req_ack), .m_cmd(m_cmd),
    .m_width(m_width), .m_addr(m_addr), .m_bl(m_bl),
    .m_wdata(m_wdata), .m_rdata(m_rdata), .m_resp(m_resp),
    .s_req(s_req), .s_req_ack(s_req_ack), .s_cmd(s_cmd),
    .s_width(s_width), .s_addr(s_addr), .s_bl(s_bl),
    .s_wdata(s_wdata), .s_rdata(s_rdata), .s_resp(s_resp),
    .gnt_id(gnt_id), .busy(busy), .tmo_err(tmo_err)
  );

  task automatic chk(input string tag, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]   bseq [5] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b11};
  logic [7:0]   brsp [5] = '{8'h04, 8'h00, 8'h04, 8'h04, 8'h0C};
  logic         bbsy [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0]   rord [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0]   rack [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [7:0]   rrsp [5] = '{8'h01, 8'h04, 8'h10, 8'h40, 8'h01};
  logic [31:0]  rwd  [5] = '{32'h1111_1111, 32'h2222_2222,
                             32'h3333_3333, 32'h4444_4444,
                             32'h1111_1111};

  initial begin
    rst       = 1'b1;
    m_req     = '0;
    m_cmd     = '0;
    m_width   = '0;
    m_addr    = '0;
    m_bl      = '0;
    m_wdata   = '0;
    s_req_ack = 1'b0;
    s_rdata   = '0;
    s_resp    = 2'b00;
    step();
    step();
    chk("rst_sreq", s_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt_id, 0);
    chk("rst_resp", m_resp, 0);
    chk("rst_rdata", m_rdata, 0);
    chk("rst_tmo", tmo_err, 0);
    chk("rst_ack", m_req_ack, 0);
    chk("rst_saddr", s_addr, 0);
    rst = 1'b0;
    step();

    // single read, master 2
    m_req            = 4'b0100;
    m_addr[64 +: 32] = 32'h100;
    m_bl[6 +: 3]     = 3'd1;
    m_width[4 +: 2]  = 2'b10;
    #1;
    chk("t1_nocomb", s_req, 0);
    step();
    chk("t1_sreq", s_req, 1);
    chk("t1_gnt", gnt_id, 2);
    chk("t1_addr", s_addr, 32'h100);
    chk("t1_width", s_width, 2'b10);
    chk("t1_cmd", s_cmd, 0);
    chk("t1_noack", m_req_ack, 0);
    step();
    chk("t1_sreq2", s_req, 1);
    s_req_ack = 1'b1;
    #1;
    chk("t1_ack", m_req_ack, 4'b0100);
    step();
    s_req_ack = 1'b0;
    m_req     = '0;
    s_resp    = 2'b01;
    s_rdata   = 32'hDEAD;
    #1;
    chk("t1_resp", m_resp, 8'h10);
    chk("t1_rdata", m_rdata, {32'h0, 32'hDEAD, 64'h0});
    chk("t1_busy", busy, 1);
    step();
    s_resp = 2'b00;
    #1;
    chk("t1_idle", busy, 0);
    chk("t1_resp0", m_resp, 0);

    // burst read, master 1, bl=4
    m_req        = 4'b0010;
    m_bl[3 +: 3] = 3'd4;
    step();
    chk("t2_gnt", gnt_id, 1);
    chk("t2_bl", s_bl, 3'd4);
    s_req_ack = 1'b1;
    step();
    s_req_ack = 1'b0;
    m_req     = '0;
    for (int i = 0; i < 5; i++) begin
      s_resp  = bseq[i];
      s_rdata = 32'hA0 + i;
      #1;
      chk("t2_resp", m_resp, brsp[i]);
      chk("t2_rdata", m_rdata, {64'h0, 32'hA0 + i, 32'h0});
      step();
      chk("t2_busy", busy, bbsy[i]);
    end
    s_resp = 2'b00;

    // round robin from reset, all masters write
    rst = 1'b1;
    #1;
    rst     = 1'b0;
    m_req   = 4'hF;
    m_cmd   = 4'hF;
    m_bl    = '0;
    m_wdata = {32'h4444_4444, 32'h3333_3333,
               32'h2222_2222, 32'h1111_1111};
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_gnt", gnt_id, rord[k]);
      chk("t3_sreq", s_req, 1);
      chk("t3_wdata", s_wdata, rwd[k]);
      s_req_ack = 1'b1;
      #1;
      chk("t3_ack", m_req_ack, rack[k]);
      step();
      s_req_ack = 1'b0;
      s_resp    = 2'b01;
      #1;
      chk("t3_resp", m_resp, rrsp[k]);
      step();
      s_resp = 2'b00;
      #1;
      chk("t3_turn", s_req, 0);
      chk("t3_tbusy", busy, 0);
    end

    // error abort: master 1 burst, master 3 waiting
    m_req        = 4'b1010;
    m_cmd        = 4'b1000;
    m_bl[3 +: 3] = 3'd4;
    step();
    chk("t4_gnt", gnt_id, 1);
    s_req_ack = 1'b1;
    step();
    s_req_ack = 1'b0;
    m_req     = 4'b1000;
    s_resp    = 2'b01;
    #1;
    chk("t4_ok", m_resp, 8'h04);
    step();
    chk("t4_busy", busy, 1);
    s_resp = 2'b10;
    #1;
    chk("t4_er", m_resp, 8'h08);
    step();
    s_resp = 2'b00;
    #1;
    chk("t4_idle", busy, 0);
    step();
    chk("t4_next", gnt_id, 3);
    chk("t4_nsreq", s_req, 1);
    chk("t4_ncmd", s_cmd, 1);
    s_req_ack = 1'b1;
    step();
    s_req_ack = 1'b0;
    m_req     = '0;
    s_resp    = 2'b01;
    step();
    s_resp = 2'b00;

    // watchdog on master 0
    m_req        = 4'b0001;
    m_cmd        = '0;
    m_bl[0 +: 3] = 3'd1;
    step();
    chk("t5_gnt", gnt_id, 0);
    s_req_ack = 1'b1;
    step();
    s_req_ack = 1'b0;
    m_req     = '0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (c < 8) chk("t5_quiet", m_resp, 0);
      else       chk("t5_er", m_resp, 8'h02);
      chk("t5_tmo0", tmo_err, 0);
      step();
    end
    chk("t5_tmo", tmo_err, 1);
    chk("t5_idle", busy, 0);
    s_resp = 2'b01;
    #1;
    chk("t5_late", m_resp, 0);
    step();
    s_resp = 2'b00;
    chk("t5_sticky", tmo_err, 1);

    // async reset mid-burst
    m_req        = 4'b0100;
    m_bl[6 +: 3] = 3'd4;
    step();
    chk("t6_gnt", gnt_id, 2);
    s_req_ack = 1'b1;
    step();
    s_req_ack = 1'b0;
    s_resp    = 2'b01;
    s_rdata   = 32'h55;
    #1;
    chk("t6_resp", m_resp, 8'h10);
    rst = 1'b1;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_mresp", m_resp, 0);
    chk("t6_rdata", m_rdata, 0);
    chk("t6_gnt0", gnt_id, 0);
    chk("t6_tmo", tmo_err, 0);
    chk("t6_sreq", s_req, 0);
    chk("t6_ack", m_req_ack, 0);
    rst    = 1'b0;
    s_resp = 2'b00;
    m_req  = 4'hF;
    m_cmd  = 4'hF;
    step();
    chk("t6_prio", gnt_id, 0);
    chk("t6_req", s_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
